// File: rtl/uart_rx_link_pkg.sv
// Shared CSR definitions for the UART receive register.
package uart_rx_link_pkg;

    localparam logic [11:0] ADDR_UART_RX = 12'h010;

    typedef struct packed {
        logic       valid;
        logic       oflow;
        logic [7:0] data;
    } uart_rx_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: power-of-2 depth, wrap-bit pointers, combinational head read.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic          wr_en;
    logic          rd_en;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + PW'(1);
            if (rd_en) rd_q <= rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_link.sv
// UART 8N1 receiver feeding the UART_RX CSR holding register.
// Define UART_RX_FIFO_EN to add the RxFIFO behind the holding register.
module uart_rx_link
    import uart_rx_link_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     uart_rxd,
    input  logic     csr_rd,
    output uart_rx_t csr_rx
);

    localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    logic [1:0]       sync_q;
    logic             rxd_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             push_c;
    uart_rx_t         rx_q, rx_d;

    assign rxd_s  = sync_q[1];
    assign csr_rx = rx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            rx_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], uart_rxd};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            rx_q    <= rx_d;
        end
    end

    // Frame receiver: mid-bit sampling timed from the detected start edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        push_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d   = '0;
                    shreg_d = {rxd_s, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        push_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (rxd_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef UART_RX_FIFO_EN
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (shreg_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Read is resolved first so a same-cycle push lands in the slot it frees.
    always_comb begin
        rx_d      = rx_q;
        fifo_push = 1'b0;
        fifo_pop  = csr_rd && rx_q.valid && !fifo_empty;
        if (csr_rd) rx_d.oflow = 1'b0;
        if (csr_rd && rx_q.valid) begin
            if (fifo_empty) rx_d.valid = 1'b0;
            else            rx_d.data  = fifo_dout;
        end
        if (push_c) begin
            if (!rx_d.valid) begin
                rx_d.valid = 1'b1;
                rx_d.data  = shreg_q;
            end else if (!fifo_full || fifo_pop) begin
                fifo_push = 1'b1;
            end else begin
                rx_d.oflow = 1'b1;
            end
        end
    end
`else
    // Holding register only: a read always empties it.
    always_comb begin
        rx_d = rx_q;
        if (csr_rd) begin
            rx_d.oflow = 1'b0;
            rx_d.valid = 1'b0;
        end
        if (push_c) begin
            if (!rx_d.valid) begin
                rx_d.valid = 1'b1;
                rx_d.data  = shreg_q;
            end else begin
                rx_d.oflow = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_link.sv
// Directed + randomized bench for uart_rx_link against a queue-based CSR model.
module tb_uart_rx_link;
    import uart_rx_link_pkg::*;

    localparam int CLK_HZ     = 1_152_000;
    localparam int BAUD       = 115_200;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF       = DIV / 2;
    // Edges from line fall to the stop-bit sample: 2 sync stages, 1 to leave idle,
    // half a bit to the start centre, then 8 data bits and the stop bit.
    localparam int PUSH_LAT   = 2 + 1 + HALF + 9 * DIV;
    localparam int GAP        = 6;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 0;
`endif

    logic     clk;
    logic     rst_n;
    logic     uart_rxd;
    logic     csr_rd;
    uart_rx_t csr_rx;

    int n_chk  = 0;
    int n_pass = 0;

    logic       m_valid;
    logic       m_oflow;
    logic [7:0] m_data;
    logic [7:0] m_q[$];

    uart_rx_link #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .csr_rd   (csr_rd),
        .csr_rx   (csr_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] model_val();
        return {m_valid, m_oflow, m_data};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_oflow = 1'b0;
        m_data  = 8'h00;
        m_q.delete();
    endtask

    task automatic model_read();
        if (m_valid) begin
            if (m_q.size() > 0) m_data = m_q.pop_front();
            else                m_valid = 1'b0;
        end
        m_oflow = 1'b0;
    endtask

    task automatic model_push(input logic [7:0] b);
        if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = b;
        end else if (m_q.size() < CAP) begin
            m_q.push_back(b);
        end else begin
            m_oflow = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one frame from a negedge; optional CSR read lands on the push edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_at_push);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int c = 0; c < 10 * DIV + GAP; c++) begin
            @(negedge clk);
            if (c == PUSH_LAT - 1) check("pre_push", csr_rx, model_val());
            if (c == PUSH_LAT) begin
                if (rd_at_push) model_read();
                if (stop) model_push(b);
                check("post_push", csr_rx, model_val());
            end
            uart_rxd = (c < 10 * DIV) ? frame[c / DIV] : 1'b1;
            csr_rd   = rd_at_push && (c == PUSH_LAT - 1);
        end
    endtask

    task automatic do_read(input string tag);
        @(negedge clk);
        csr_rd = 1'b1;
        @(negedge clk);
        csr_rd = 1'b0;
        model_read();
        check(tag, csr_rx, model_val());
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        int         nrd;

        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        csr_rd   = 1'b0;
        model_reset();
        idle(3);
        check("reset", csr_rx, 10'h000);
        rst_n = 1'b1;
        idle(5);
        check("idle_after_reset", csr_rx, 10'h000);

        // Single frame, then one read
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_hold", csr_rx, 10'h2A5);
        do_read("a5_read");
        check("a5_read_const", csr_rx, 10'h0A5);

        // Short low glitch must not start a frame
        @(negedge clk);
        uart_rxd = 1'b0;
        idle(3);
        uart_rxd = 1'b1;
        idle(40);
        check("glitch", csr_rx, model_val());
        send_frame(8'h5A, 1'b1, 1'b0);
        do_read("after_glitch_read");

        // Six frames with no reads: fill, then overflow
        for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1, 1'b0);
        check("six_frames", csr_rx, model_val());
        for (int i = 0; i < 6; i++) do_read($sformatf("drain%0d", i));

        // Framing error discards the byte; next good frame is received
        send_frame(8'h3C, 1'b0, 1'b0);
        check("framing_err", csr_rx, model_val());
        send_frame(8'h7E, 1'b1, 1'b0);
        check("after_ferr", csr_rx[7:0], 8'h7E);

        // Read coinciding with push while holding valid and FIFO full
        for (int i = 0; i < CAP; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1);
        check("same_cycle_no_oflow", 10'(csr_rx.oflow), 10'h000);
        for (int i = 0; i <= CAP + 1; i++) do_read($sformatf("sc_drain%0d", i));

        // Randomized traffic with reads between frames and on the push edge
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0));
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) do_read($sformatf("rnd%0d_rd%0d", i, r));
        end

        // Reset in the middle of a frame after a byte is held
        send_frame(8'hC3, 1'b1, 1'b0);
        for (int c = 0; c < 5 * DIV + 5; c++) begin
            @(negedge clk);
            uart_rxd = (c < DIV) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_frame_reset", csr_rx, 10'h000);
        uart_rxd = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(150);
        check("partial_never_pushed", csr_rx, model_val());
        send_frame(8'h99, 1'b1, 1'b0);
        check("post_reset_frame", csr_rx, 10'h299);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
